branch_predict_unit: RTL and testbench

//  Parametrised branch target buffer + saturating-counter predictor for the 5-stage MIPS pipeline.

---
 rtl/branch_predict_unit_if.sv | 30 +++
 rtl/branch_predict_unit.sv | 122 ++++++++++++
 tb/tb_branch_predict_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and memory-stage resolve bundle between the datapath (master) and the branch predictor (slave).
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic              res_is_uncond;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] correct_pc;

  modport master (
    output fetch_pc, res_valid, res_pc, res_is_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, mispredict, correct_pc
  );

  modport slave (
    input  fetch_pc, res_valid, res_pc, res_is_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pred_taken, pred_target, mispredict, correct_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// BTB + saturating-counter predictor: zero-cycle lookup/mispredict, tables update on CLK; no backpressure.
// Optional macro BPU_STATS_EN adds saturating branch and mispredict counters.
module branch_predict_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_W       = 2,
  parameter int ADDR_W      = 32
) (
  input  logic CLK,
  input  logic nRST,
  branch_predict_unit_if.slave bpu
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0]  CTR_MAX = '1;
  localparam logic [CTR_W-1:0]  CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(4);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [ADDR_W-1:0]      target_q [BTB_ENTRIES];
  logic [CTR_W-1:0]       ctr_q    [BTB_ENTRIES];

  // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = bpu.fetch_pc[IDX_W+1:2];
  assign f_tag = bpu.fetch_pc[ADDR_W-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bpu.pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
  assign bpu.pred_target = bpu.pred_taken ? target_q[f_idx] : bpu.fetch_pc + PC_INC;

  assign bpu.mispredict = bpu.res_valid &&
                          ((bpu.res_pred_taken != bpu.res_taken) ||
                           (bpu.res_taken && (bpu.res_pred_target != bpu.res_target)));
  assign bpu.correct_pc = bpu.res_taken ? bpu.res_target : bpu.res_pc + PC_INC;

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  assign r_idx = bpu.res_pc[IDX_W+1:2];
  assign r_tag = bpu.res_pc[ADDR_W-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  logic             upd_en;
  logic             upd_tgt_en;
  logic             upd_alloc;
  logic [CTR_W-1:0] upd_ctr;

  always_comb begin
    upd_en     = 1'b0;
    upd_tgt_en = 1'b0;
    upd_alloc  = 1'b0;
    upd_ctr    = ctr_q[r_idx];
    if (bpu.res_valid) begin
      if (r_hit) begin
        upd_en = 1'b1;
        if (bpu.res_is_uncond) begin
          upd_ctr    = CTR_MAX;
          upd_tgt_en = 1'b1;
        end else if (bpu.res_taken) begin
          if (ctr_q[r_idx] != CTR_MAX) upd_ctr = ctr_q[r_idx] + CTR_W'(1);
          upd_tgt_en = 1'b1;
        end else if (ctr_q[r_idx] != '0) begin
          upd_ctr = ctr_q[r_idx] - CTR_W'(1);
        end
      end else if (bpu.res_taken || bpu.res_is_uncond) begin
        // Jumps start strongly taken; conditional branches start weakly taken.
        upd_en     = 1'b1;
        upd_tgt_en = 1'b1;
        upd_alloc  = 1'b1;
        upd_ctr    = bpu.res_is_uncond ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_en) begin
      ctr_q[r_idx] <= upd_ctr;
      if (upd_tgt_en) target_q[r_idx] <= bpu.res_target;
      if (upd_alloc) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (bpu.res_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (bpu.mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  // Word-aligned PCs: the byte-offset bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bpu.fetch_pc[1:0], bpu.res_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit (16 entries, 2-bit counters, 32-bit PCs).
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_W(32)) bus ();

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit #(.BTB_ENTRIES(16), .CTR_W(2), .ADDR_W(32)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bpu  (bus)
`ifdef BPU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] cpc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input string nm, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic unc, input logic tk,
                       input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt,
                       input logic ept, input logic [31:0] etgt,
                       input logic emp, input logic [31:0] ecpc);
    exp_t e;
    bus.fetch_pc        = fpc;
    bus.res_valid       = rv;
    bus.res_pc          = rpc;
    bus.res_is_uncond   = unc;
    bus.res_taken       = tk;
    bus.res_target      = rtgt;
    bus.res_pred_taken  = rpt;
    bus.res_pred_target = rptgt;
    e.name = nm; e.pt = ept; e.tgt = etgt; e.mp = emp; e.cpc = ecpc;
    sb.push_back(e);
  endtask

  task automatic drive_f(input string nm, input logic [31:0] fpc,
                         input logic ept, input logic [31:0] etgt);
    drive(nm, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ept, etgt, 1'b0, 32'h4);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive_f("rst_lookup", 32'h40, 1'b0, 32'h44);
        1: drive_f("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        default: drive("rst_res", 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44,
                       1'b0, 32'h44, 1'b1, 32'h80);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
`ifdef BPU_STATS_EN
    total++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      bad++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
`endif
    drive_f("idle", 32'h0, 1'b0, 32'h4);
    void'(sb.pop_back());
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_alloc();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive("alloc_res", 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44,
                 1'b0, 32'h44, 1'b1, 32'h80);
        1: drive_f("alloc_hit", 32'h40, 1'b1, 32'h80);
        default: drive_f("alloc_tag_miss", 32'h140, 1'b0, 32'h144);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
  endtask

  // Entry 0x40 starts at weak-taken (2); walk it down, back up and down again.
  task automatic test_not_taken();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive("nt1", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80,
                 1'b1, 32'h80, 1'b1, 32'h44);
        1: drive_f("nt1_look", 32'h40, 1'b0, 32'h44);
        2: drive("nt2", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80,
                 1'b0, 32'h44, 1'b1, 32'h44);
        3: drive("nt_floor_taken", 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44,
                 1'b0, 32'h44, 1'b1, 32'h80);
        4: drive_f("nt_still_weak", 32'h40, 1'b0, 32'h44);
        default: drive("nt_correct", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44,
                       1'b0, 32'h44, 1'b0, 32'h44);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
  endtask

  task automatic test_alias();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive("al_a", 32'h80, 1'b1, 32'h40, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h44,
                 1'b0, 32'h84, 1'b1, 32'h1000);
        1: drive("al_b", 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h84,
                 1'b0, 32'h44, 1'b1, 32'h2000);
        2: drive_f("al_old_miss", 32'h40, 1'b0, 32'h44);
        3: drive_f("al_new_hit", 32'h80, 1'b1, 32'h2000);
        4: drive("al_tgt_wrong", 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h2000, 1'b1, 32'h2004,
                 1'b1, 32'h2000, 1'b1, 32'h2000);
        5: drive("al_sat_top", 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h2000, 1'b1, 32'h2000,
                 1'b1, 32'h2000, 1'b0, 32'h2000);
        6: drive("al_dec", 32'h80, 1'b1, 32'h80, 1'b0, 1'b0, 32'h2000, 1'b1, 32'h2000,
                 1'b1, 32'h2000, 1'b1, 32'h84);
        default: drive_f("al_after_dec", 32'h80, 1'b1, 32'h2000);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
  endtask

  task automatic test_jr();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: drive("jr_alloc", 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104,
                 1'b0, 32'h104, 1'b1, 32'h200);
        1: drive("jr_retarget", 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200,
                 1'b1, 32'h200, 1'b1, 32'h300);
        2: drive_f("jr_new_tgt", 32'h100, 1'b1, 32'h300);
        3: drive("jr_dec1", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300,
                 1'b1, 32'h300, 1'b1, 32'h104);
        4: drive_f("jr_strong", 32'h100, 1'b1, 32'h300);
        5: drive("jr_dec2", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300,
                 1'b1, 32'h300, 1'b1, 32'h104);
        6: drive("jr_uncond_hit", 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0, 32'h104,
                 1'b0, 32'h104, 1'b1, 32'h300);
        7: drive("jr_dec3", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300,
                 1'b1, 32'h300, 1'b1, 32'h104);
        default: drive_f("jr_max_held", 32'h100, 1'b1, 32'h300);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive("b2b_0", 32'h44, 1'b1, 32'h44, 1'b0, 1'b1, 32'h500, 1'b0, 32'h48,
                 1'b0, 32'h48, 1'b1, 32'h500);
        1: drive("b2b_1", 32'h44, 1'b1, 32'h48, 1'b0, 1'b1, 32'h600, 1'b0, 32'h4C,
                 1'b1, 32'h500, 1'b1, 32'h600);
        2: drive("b2b_2", 32'h48, 1'b1, 32'h4C, 1'b0, 1'b1, 32'h700, 1'b0, 32'h50,
                 1'b1, 32'h600, 1'b1, 32'h700);
        3: drive_f("b2b_look3", 32'h4C, 1'b1, 32'h700);
        4: drive_f("b2b_idx0_kept", 32'h100, 1'b1, 32'h300);
        5: drive_f("b2b_wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);
        6: drive("b2b_wrap_res", 32'h10, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                 1'b0, 32'h14, 1'b0, 32'h0);
        default: drive_f("b2b_no_alloc", 32'hFFFF_FFFC, 1'b0, 32'h0);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      tick();
    end
  endtask

  // Reset lands while a taken branch is being resolved: nothing may be allocated.
  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive("rm_res", 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h900, 1'b0, 32'h44,
                 1'b0, 32'h44, 1'b1, 32'h900);
        1: drive_f("rm_cleared", 32'h100, 1'b0, 32'h104);
        2: drive_f("rm_no_alloc", 32'h40, 1'b0, 32'h44);
        default: drive_f("rm_idx1_clear", 32'h44, 1'b0, 32'h48);
      endcase
      #1;
      e = sb.pop_front();
      total += 4;
      if (bus.pred_taken !== e.pt) begin bad++; $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, bus.pred_taken, e.pt); end
      if (bus.pred_target !== e.tgt) begin bad++; $display("FAIL %s pred_target got=%h exp=%h", e.name, bus.pred_target, e.tgt); end
      if (bus.mispredict !== e.mp) begin bad++; $display("FAIL %s mispredict got=%0b exp=%0b", e.name, bus.mispredict, e.mp); end
      if (bus.correct_pc !== e.cpc) begin bad++; $display("FAIL %s correct_pc got=%h exp=%h", e.name, bus.correct_pc, e.cpc); end
      if (i == 0) nrst = 1'b0;
      if (i == 1) nrst = 1'b1;
      tick();
    end
`ifdef BPU_STATS_EN
    total++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      bad++; $display("FAIL rm_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_not_taken();
    test_alias();
    test_jr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
